reg_file: RTL

// - 32 x 32-bit MIPS general-purpose register file; two asynchronous read ports, one synchronous write port.
// - Sits directly upstream of the 32-bit 2:1 operand mux: RD1 drives ALU operand A, RD2 drives the mux A input.
// - Mux B input carries the sign-extended immediate; S is ALUSrc.
// - Provides $zero semantics and same-cycle write-to-read bypass so decode sees the value being written back.

---
 rtl/mips_pkg.sv | 19 +
 rtl/reg_read_port.sv | 39 +++
 rtl/reg_file.sv | 73 +++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and constants, used by the register file,
// the operand mux and the ALU.
package mips_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 2 ** REG_ADDR_W;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0]     word_t;

   // True when an address names a writable register (anything but $zero).
   function automatic logic is_writable(input reg_addr_t addr);
      return addr != REG_ZERO;
   endfunction

endpackage : mips_pkg

// File: rtl/reg_read_port.sv
// One combinational read port of the register file: array select,
// $zero forcing, same-cycle write-through from writeback, and reset gating.
import mips_pkg::*;

module reg_read_port #(
   parameter int DATA_W   = mips_pkg::DATA_W,
   parameter int ADDR_W   = mips_pkg::REG_ADDR_W,
   parameter int NUM_REGS = 2 ** ADDR_W
) (
   input  logic                              rst,
   input  logic [ADDR_W-1:0]                 ra,
   input  logic                              we,
   input  logic [ADDR_W-1:0]                 wa,
   input  logic [DATA_W-1:0]                 wd,
   input  logic [NUM_REGS-1:0][DATA_W-1:0]   regs,
   output logic [DATA_W-1:0]                 rd
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic ra_is_zero;
   logic bypass_hit;

   assign ra_is_zero = (ra == ZERO_ADDR);
   // Write-through only for a real write: $zero is never forwarded.
   assign bypass_hit = we && (wa == ra) && (wa != ZERO_ADDR);

   always_comb begin
      rd = '0;
      if (!rst && !ra_is_zero) begin
         if (bypass_hit) begin
            rd = wd;
         end else begin
            rd = regs[ra];
         end
      end
   end

endmodule : reg_read_port

// File: rtl/reg_file.sv
// 32 x 32 MIPS register file: two asynchronous read ports with write-through
// bypass, one synchronous write port, $zero hardwired to 0.
import mips_pkg::*;

module reg_file #(
   parameter int DATA_W   = mips_pkg::DATA_W,
   parameter int ADDR_W   = mips_pkg::REG_ADDR_W,
   parameter int NUM_REGS = 2 ** ADDR_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] RA1,
   input  logic [ADDR_W-1:0] RA2,
   input  logic [ADDR_W-1:0] WA,
   input  logic [DATA_W-1:0] WD,
   input  logic              WE,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   // Reads and writes are unconditional: no valid/ready, data is valid once
   // the addresses settle and a write commits on the edge it is presented.
   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
   logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;

   always_comb begin
      regs_d = regs_q;
      if (WE && (WA != ZERO_ADDR)) begin
         regs_d[WA] = WD;
      end
      regs_d[0] = '0;
   end

   // Reset dominates any write presented on the same edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   reg_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_read_port_1 (
      .rst  (RST),
      .ra   (RA1),
      .we   (WE),
      .wa   (WA),
      .wd   (WD),
      .regs (regs_q),
      .rd   (RD1)
   );

   reg_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_read_port_2 (
      .rst  (RST),
      .ra   (RA2),
      .we   (WE),
      .wa   (WA),
      .wd   (WD),
      .regs (regs_q),
      .rd   (RD2)
   );

endmodule : reg_file
